// File: rtl/pmem_arbiter_if.sv
// Bundles the I-cache, D-cache and physical-memory buses that meet at the pmem arbiter.
// The slave view belongs to the arbiter; the master view belongs to the caches and memory around it.
interface pmem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128
);

   logic              i_read;
   logic [ADDR_W-1:0] i_address;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;

   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_address;
   logic [LINE_W-1:0] d_wdata;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;

   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_address;
   logic [LINE_W-1:0] pmem_wdata;
   logic [LINE_W-1:0] pmem_rdata;
   logic              pmem_resp;

   logic              grant_d;

   modport slave (
      input  i_read, i_address,
      input  d_read, d_write, d_address, d_wdata,
      input  pmem_rdata, pmem_resp,
      output i_rdata, i_resp,
      output d_rdata, d_resp,
      output pmem_read, pmem_write, pmem_address, pmem_wdata,
      output grant_d
   );

   modport master (
      output i_read, i_address,
      output d_read, d_write, d_address, d_wdata,
      output pmem_rdata, pmem_resp,
      input  i_rdata, i_resp,
      input  d_rdata, d_resp,
      input  pmem_read, pmem_write, pmem_address, pmem_wdata,
      input  grant_d
   );

endinterface

// File: rtl/pmem_arbiter.sv
// Shares one physical-memory port between the read-only I-cache and the read/write D-cache.
// It serves one line transaction at a time, and every output comes straight from a register.
module pmem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128
) (
   input  logic          clk,
   input  logic          reset_n,
   pmem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      SERVE_I,
      SERVE_D,
      DONE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              last_d;
   logic              last_d_nxt;

   logic              pmem_read_q;
   logic              pmem_read_nxt;
   logic              pmem_write_q;
   logic              pmem_write_nxt;
   logic              grant_d_q;
   logic              grant_d_nxt;
   logic              i_resp_q;
   logic              i_resp_nxt;
   logic              d_resp_q;
   logic              d_resp_nxt;

   logic [ADDR_W-1:0] address_q;
   logic [ADDR_W-1:0] address_nxt;
   logic [LINE_W-1:0] wdata_q;
   logic [LINE_W-1:0] wdata_nxt;
   logic [LINE_W-1:0] i_rdata_q;
   logic [LINE_W-1:0] i_rdata_nxt;
   logic [LINE_W-1:0] d_rdata_q;
   logic [LINE_W-1:0] d_rdata_nxt;

   logic              req_i;
   logic              req_d;
   logic              pick_d;

   assign req_i = bus.i_read;
   assign req_d = bus.d_read | bus.d_write;

   // When both sides ask at once, the side that lost last time wins. Reset leaves I as the
   // last winner, so D takes the first tie.
   assign pick_d = req_d & (~req_i | ~last_d);

   // The address and write data are captured once, at grant time. They stay in the pmem
   // registers until the transaction ends, so the caches may change their buses freely.
   always_comb begin
      state_nxt      = state;
      last_d_nxt     = last_d;
      pmem_read_nxt  = pmem_read_q;
      pmem_write_nxt = pmem_write_q;
      grant_d_nxt    = grant_d_q;
      address_nxt    = address_q;
      wdata_nxt      = wdata_q;
      i_rdata_nxt    = i_rdata_q;
      d_rdata_nxt    = d_rdata_q;
      i_resp_nxt     = 1'b0;
      d_resp_nxt     = 1'b0;

      case (state)
         IDLE: begin
            if (pick_d) begin
               state_nxt      = SERVE_D;
               last_d_nxt     = 1'b1;
               grant_d_nxt    = 1'b1;
               address_nxt    = bus.d_address;
               wdata_nxt      = bus.d_wdata;
               pmem_write_nxt = bus.d_write;
               pmem_read_nxt  = ~bus.d_write;
            end else if (req_i) begin
               state_nxt      = SERVE_I;
               last_d_nxt     = 1'b0;
               grant_d_nxt    = 1'b0;
               address_nxt    = bus.i_address;
               pmem_write_nxt = 1'b0;
               pmem_read_nxt  = 1'b1;
            end
         end

         SERVE_I: begin
            if (bus.pmem_resp) begin
               state_nxt      = DONE;
               i_rdata_nxt    = bus.pmem_rdata;
               i_resp_nxt     = 1'b1;
               pmem_read_nxt  = 1'b0;
               pmem_write_nxt = 1'b0;
            end
         end

         SERVE_D: begin
            // For a writeback the returned line is meaningless but is loaded all the same.
            if (bus.pmem_resp) begin
               state_nxt      = DONE;
               d_rdata_nxt    = bus.pmem_rdata;
               d_resp_nxt     = 1'b1;
               pmem_read_nxt  = 1'b0;
               pmem_write_nxt = 1'b0;
               grant_d_nxt    = 1'b0;
            end
         end

         DONE: begin
            state_nxt = IDLE;
         end

         default: begin
            state_nxt      = IDLE;
            pmem_read_nxt  = 1'b0;
            pmem_write_nxt = 1'b0;
            grant_d_nxt    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         last_d       <= 1'b0;
         pmem_read_q  <= 1'b0;
         pmem_write_q <= 1'b0;
         grant_d_q    <= 1'b0;
         i_resp_q     <= 1'b0;
         d_resp_q     <= 1'b0;
      end else begin
         state        <= state_nxt;
         last_d       <= last_d_nxt;
         pmem_read_q  <= pmem_read_nxt;
         pmem_write_q <= pmem_write_nxt;
         grant_d_q    <= grant_d_nxt;
         i_resp_q     <= i_resp_nxt;
         d_resp_q     <= d_resp_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         address_q <= '0;
         wdata_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         address_q <= address_nxt;
         wdata_q   <= wdata_nxt;
         i_rdata_q <= i_rdata_nxt;
         d_rdata_q <= d_rdata_nxt;
      end
   end

   assign bus.pmem_read    = pmem_read_q;
   assign bus.pmem_write   = pmem_write_q;
   assign bus.pmem_address = address_q;
   assign bus.pmem_wdata   = wdata_q;
   assign bus.grant_d      = grant_d_q;
   assign bus.i_resp       = i_resp_q;
   assign bus.i_rdata      = i_rdata_q;
   assign bus.d_resp       = d_resp_q;
   assign bus.d_rdata      = d_rdata_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Testbench for pmem_arbiter: directed scenarios plus randomized two-cache traffic.
// Expected timing comes from the grant/latency rules (strobe at t+1..t+len, resp at t+len+1).
module tb_pmem_arbiter;

   localparam int ADDR_W = 16;
   localparam int LINE_W = 128;

   logic clk = 1'b0;
   logic reset_n;

   always #5 clk = ~clk;

   pmem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

   pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int                n_checks = 0;
   int                n_fail   = 0;
   int                mem_delay = 1;
   int                mem_cnt   = 0;
   logic [LINE_W-1:0] mem_data  = '0;

   // Memory model: answers a held strobe after mem_delay cycles, with mem_data, for one cycle.
   always @(negedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.pmem_resp  = 1'b0;
         bus.pmem_rdata = '0;
         mem_cnt        = 0;
      end else if (bus.pmem_resp) begin
         bus.pmem_resp = 1'b0;
         mem_cnt       = 0;
      end else if (bus.pmem_read || bus.pmem_write) begin
         mem_cnt = mem_cnt + 1;
         if (mem_cnt >= mem_delay) begin
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = mem_data;
         end
      end else begin
         mem_cnt = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic reset_pulse();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      reset_n       = 1'b0;
      bus.i_read    = 1'b0;
      bus.i_address = '0;
      bus.d_read    = 1'b0;
      bus.d_write   = 1'b0;
      bus.d_address = '0;
      bus.d_wdata   = '0;
      repeat (3) tick();
      n_checks++;
      if ({bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp, bus.grant_d} !== 5'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_ctrl: got %b expected 00000", {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp, bus.grant_d});
      end
      n_checks++;
      if (bus.pmem_address !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_address: got %h expected 0", bus.pmem_address);
      end
      n_checks++;
      if (bus.pmem_wdata !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_wdata: got %h expected 0", bus.pmem_wdata);
      end
      n_checks++;
      if (bus.i_rdata !== '0 || bus.d_rdata !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_rdata: got i=%h d=%h expected 0", bus.i_rdata, bus.d_rdata);
      end
      reset_n = 1'b1;
      tick();
      n_checks++;
      if (bus.pmem_read !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL idle_no_req: got pmem_read=%b expected 0", bus.pmem_read);
      end
   endtask

   task automatic test_i_only();
      logic exp_strobe;
      logic [LINE_W-1:0] line_a;
      line_a        = {8{16'hAAAA}};
      mem_delay     = 3;
      mem_data      = line_a;
      bus.i_address = 16'h1230;
      bus.i_read    = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         tick();
         exp_strobe = (c >= 1 && c <= 3);
         n_checks++;
         if (bus.pmem_read !== exp_strobe || bus.pmem_write !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL i_only_strobe c=%0d: got r=%b w=%b expected r=%b w=0", c, bus.pmem_read, bus.pmem_write, exp_strobe);
         end
         if (exp_strobe) begin
            n_checks++;
            if (bus.pmem_address !== 16'h1230) begin
               n_fail++;
               $display("[TB] FAIL i_only_addr c=%0d: got %h expected 1230", c, bus.pmem_address);
            end
         end
         n_checks++;
         if (bus.i_resp !== (c == 4) || bus.d_resp !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL i_only_resp c=%0d: got i=%b d=%b expected i=%b d=0", c, bus.i_resp, bus.d_resp, (c == 4));
         end
         if (c >= 4) begin
            n_checks++;
            if (bus.i_rdata !== line_a) begin
               n_fail++;
               $display("[TB] FAIL i_only_rdata c=%0d: got %h expected %h", c, bus.i_rdata, line_a);
            end
         end
         if (c == 4) bus.i_read = 1'b0;
      end
   endtask

   task automatic test_d_write();
      logic exp_strobe;
      logic [LINE_W-1:0] wline;
      wline         = 128'h0123456789ABCDEF0123456789ABCDEF;
      mem_delay     = 4;
      mem_data      = {4{$urandom}};
      bus.d_address = 16'h8000;
      bus.d_wdata   = wline;
      bus.d_read    = 1'b0;
      bus.d_write   = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         tick();
         exp_strobe = (c >= 1 && c <= 4);
         n_checks++;
         if (bus.pmem_write !== exp_strobe || bus.pmem_read !== 1'b0 || bus.grant_d !== exp_strobe) begin
            n_fail++;
            $display("[TB] FAIL d_write_strobe c=%0d: got w=%b r=%b g=%b expected w=%b r=0 g=%b", c, bus.pmem_write, bus.pmem_read, bus.grant_d, exp_strobe, exp_strobe);
         end
         if (exp_strobe) begin
            n_checks++;
            if (bus.pmem_address !== 16'h8000 || bus.pmem_wdata !== wline) begin
               n_fail++;
               $display("[TB] FAIL d_write_capture c=%0d: got a=%h d=%h expected a=8000 d=%h", c, bus.pmem_address, bus.pmem_wdata, wline);
            end
         end
         n_checks++;
         if (bus.d_resp !== (c == 5) || bus.i_resp !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL d_write_resp c=%0d: got d=%b i=%b expected d=%b i=0", c, bus.d_resp, bus.i_resp, (c == 5));
         end
         if (c == 2) begin
            bus.d_address = 16'h9000;
            bus.d_wdata   = ~wline;
         end
         if (c == 5) bus.d_write = 1'b0;
      end
   endtask

   task automatic test_tie_after_reset();
      logic [LINE_W-1:0] x1;
      logic [LINE_W-1:0] x2;
      logic [LINE_W-1:0] x3;
      logic own_d;
      logic own_i;
      reset_pulse();
      x1 = {4{$urandom}};
      x2 = {4{$urandom}};
      x3 = {4{$urandom}};
      mem_delay     = 2;
      mem_data      = x1;
      bus.i_address = 16'h1A00;
      bus.d_address = 16'h2B00;
      bus.i_read    = 1'b1;
      bus.d_read    = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         own_d = (c == 1 || c == 2 || c == 9 || c == 10);
         own_i = (c == 5 || c == 6);
         n_checks++;
         if (bus.pmem_read !== (own_d | own_i) || bus.grant_d !== own_d) begin
            n_fail++;
            $display("[TB] FAIL tie_owner c=%0d: got r=%b g=%b expected r=%b g=%b", c, bus.pmem_read, bus.grant_d, own_d | own_i, own_d);
         end
         if (own_d || own_i) begin
            n_checks++;
            if (bus.pmem_address !== (own_d ? 16'h2B00 : 16'h1A00)) begin
               n_fail++;
               $display("[TB] FAIL tie_addr c=%0d: got %h expected %h", c, bus.pmem_address, own_d ? 16'h2B00 : 16'h1A00);
            end
         end
         n_checks++;
         if (bus.d_resp !== (c == 3 || c == 11) || bus.i_resp !== (c == 7)) begin
            n_fail++;
            $display("[TB] FAIL tie_resp c=%0d: got d=%b i=%b expected d=%b i=%b", c, bus.d_resp, bus.i_resp, (c == 3 || c == 11), (c == 7));
         end
         if (c == 3) begin
            n_checks++;
            if (bus.d_rdata !== x1) begin
               n_fail++;
               $display("[TB] FAIL tie_rdata_d1: got %h expected %h", bus.d_rdata, x1);
            end
            bus.d_read = 1'b0;
            mem_data   = x2;
         end
         if (c == 7) begin
            n_checks++;
            if (bus.i_rdata !== x2) begin
               n_fail++;
               $display("[TB] FAIL tie_rdata_i: got %h expected %h", bus.i_rdata, x2);
            end
            bus.i_read = 1'b0;
            mem_data   = x3;
         end
         if (c == 8) begin
            bus.i_read = 1'b1;
            bus.d_read = 1'b1;
         end
         if (c == 11) begin
            n_checks++;
            if (bus.d_rdata !== x3) begin
               n_fail++;
               $display("[TB] FAIL tie_rdata_d2: got %h expected %h", bus.d_rdata, x3);
            end
            bus.d_read = 1'b0;
            bus.i_read = 1'b0;
         end
      end
   endtask

   task automatic test_back_to_back();
      int   c;
      int   t_dec;
      int   len;
      int   grants;
      logic exp_d;
      logic reassert_i;
      logic reassert_d;
      reset_pulse();
      c = 0; t_dec = 0; grants = 0;
      exp_d = 1'b1; reassert_i = 1'b0; reassert_d = 1'b0;
      len = $urandom_range(1, 5);
      mem_delay     = len;
      bus.i_address = 16'h1111;
      bus.d_address = 16'h2222;
      bus.i_read    = 1'b1;
      bus.d_read    = 1'b1;
      while (grants < 6 && c < 300) begin
         tick();
         c++;
         if (reassert_i) bus.i_read = 1'b1;
         if (reassert_d) bus.d_read = 1'b1;
         reassert_i = 1'b0;
         reassert_d = 1'b0;
         if (c == t_dec + 1) begin
            n_checks++;
            if (bus.pmem_read !== 1'b1 || bus.grant_d !== exp_d || bus.pmem_address !== (exp_d ? 16'h2222 : 16'h1111)) begin
               n_fail++;
               $display("[TB] FAIL b2b_grant n=%0d: got r=%b g=%b a=%h expected r=1 g=%b", grants, bus.pmem_read, bus.grant_d, bus.pmem_address, exp_d);
            end
         end
         if (c == t_dec + len + 1) begin
            n_checks++;
            if (bus.d_resp !== exp_d || bus.i_resp !== !exp_d) begin
               n_fail++;
               $display("[TB] FAIL b2b_resp n=%0d: got d=%b i=%b expected d=%b i=%b", grants, bus.d_resp, bus.i_resp, exp_d, !exp_d);
            end
            grants++;
            if (exp_d) begin
               bus.d_read = 1'b0;
               reassert_d = (grants < 6);
            end else begin
               bus.i_read = 1'b0;
               reassert_i = (grants < 6);
            end
            if (grants == 6) begin
               bus.i_read = 1'b0;
               bus.d_read = 1'b0;
            end
            exp_d     = !exp_d;
            t_dec     = c + 1;
            len       = $urandom_range(1, 5);
            mem_delay = len;
         end
      end
      if (grants < 6) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL b2b_timeout: got %0d grants expected 6", grants);
      end
      bus.i_read = 1'b0;
      bus.d_read = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_op();
      logic [LINE_W-1:0] line;
      mem_delay     = 1000;
      bus.i_address = 16'h4444;
      bus.i_read    = 1'b1;
      tick();
      tick();
      n_checks++;
      if (bus.pmem_read !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL mid_reset_pre: got pmem_read=%b expected 1", bus.pmem_read);
      end
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp, bus.grant_d} !== 5'b0) begin
         n_fail++;
         $display("[TB] FAIL mid_reset_async: got %b expected 00000", {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp, bus.grant_d});
      end
      bus.i_read = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      line          = {4{$urandom}};
      mem_delay     = 2;
      mem_data      = line;
      bus.i_address = 16'h4448;
      bus.i_read    = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         tick();
         n_checks++;
         if (bus.pmem_read !== (c == 1 || c == 2) || bus.i_resp !== (c == 3)) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_after c=%0d: got r=%b resp=%b expected r=%b resp=%b", c, bus.pmem_read, bus.i_resp, (c == 1 || c == 2), (c == 3));
         end
         if (c == 3) begin
            n_checks++;
            if (bus.i_rdata !== line) begin
               n_fail++;
               $display("[TB] FAIL mid_reset_rdata: got %h expected %h", bus.i_rdata, line);
            end
            bus.i_read = 1'b0;
         end
      end
   endtask

   task automatic test_long_wait();
      logic [LINE_W-1:0] line_d;
      logic [LINE_W-1:0] line_i;
      logic own_d;
      logic own_i;
      line_d        = {4{$urandom}};
      line_i        = {4{$urandom}};
      mem_delay     = 50;
      mem_data      = line_d;
      bus.d_address = 16'h6000;
      bus.d_read    = 1'b1;
      bus.d_write   = 1'b0;
      for (int c = 1; c <= 56; c++) begin
         tick();
         own_d = (c >= 1 && c <= 50);
         own_i = (c == 53 || c == 54);
         n_checks++;
         if (bus.pmem_read !== (own_d | own_i) || bus.pmem_write !== 1'b0 || bus.grant_d !== own_d) begin
            n_fail++;
            $display("[TB] FAIL long_strobe c=%0d: got r=%b w=%b g=%b expected r=%b w=0 g=%b", c, bus.pmem_read, bus.pmem_write, bus.grant_d, own_d | own_i, own_d);
         end
         if (own_d || own_i) begin
            n_checks++;
            if (bus.pmem_address !== (own_d ? 16'h6000 : 16'h7000)) begin
               n_fail++;
               $display("[TB] FAIL long_addr c=%0d: got %h expected %h", c, bus.pmem_address, own_d ? 16'h6000 : 16'h7000);
            end
         end
         n_checks++;
         if (bus.d_resp !== (c == 51) || bus.i_resp !== (c == 55)) begin
            n_fail++;
            $display("[TB] FAIL long_resp c=%0d: got d=%b i=%b expected d=%b i=%b", c, bus.d_resp, bus.i_resp, (c == 51), (c == 55));
         end
         if (c == 3) begin
            bus.i_address = 16'h7000;
            bus.i_read    = 1'b1;
         end
         if (c == 51) begin
            n_checks++;
            if (bus.d_rdata !== line_d) begin
               n_fail++;
               $display("[TB] FAIL long_rdata_d: got %h expected %h", bus.d_rdata, line_d);
            end
            bus.d_read = 1'b0;
            mem_delay  = 2;
            mem_data   = line_i;
         end
         if (c == 55) begin
            n_checks++;
            if (bus.i_rdata !== line_i) begin
               n_fail++;
               $display("[TB] FAIL long_rdata_i: got %h expected %h", bus.i_rdata, line_i);
            end
            bus.i_read = 1'b0;
         end
      end
   endtask

   task automatic test_random_traffic();
      int                cyc;
      int                next_free;
      int                t_grant;
      int                t_len;
      int                left_i;
      int                left_d;
      int                gap_i;
      int                gap_d;
      logic              busy;
      logic              busy_d;
      logic              last_d;
      logic              gnt_i;
      logic              gnt_d;
      logic              ri;
      logic              rd;
      logic              exp_strobe;
      logic              er_i;
      logic              er_d;
      logic              wr_d;
      logic              b_write;
      logic [ADDR_W-1:0] a_i;
      logic [ADDR_W-1:0] a_d;
      logic [ADDR_W-1:0] b_addr;
      logic [LINE_W-1:0] w_d;
      logic [LINE_W-1:0] b_wdata;
      logic [LINE_W-1:0] b_rdata;
      reset_pulse();
      cyc = 0; next_free = 0; t_grant = 0; t_len = 1;
      left_i = 10; left_d = 10; gap_i = 0; gap_d = 0;
      busy = 1'b0; busy_d = 1'b0; last_d = 1'b0; gnt_i = 1'b0; gnt_d = 1'b0;
      b_write = 1'b0; b_addr = '0; b_wdata = '0; b_rdata = '0;
      a_i  = ADDR_W'($urandom);
      a_d  = ADDR_W'($urandom);
      w_d  = {4{$urandom}};
      wr_d = 1'($urandom_range(0, 1));
      while ((left_i > 0 || left_d > 0 || busy) && cyc < 3000) begin
         if (gnt_i) begin
            bus.i_address = ADDR_W'($urandom);
         end else if (gap_i > 0) begin
            gap_i--;
            bus.i_read = 1'b0;
         end else begin
            bus.i_read    = (left_i > 0);
            bus.i_address = a_i;
         end
         if (gnt_d) begin
            bus.d_address = ADDR_W'($urandom);
            bus.d_wdata   = {4{$urandom}};
         end else if (gap_d > 0) begin
            gap_d--;
            bus.d_read  = 1'b0;
            bus.d_write = 1'b0;
         end else begin
            bus.d_write   = (left_d > 0) && wr_d;
            bus.d_read    = (left_d > 0) && !wr_d;
            bus.d_address = a_d;
            bus.d_wdata   = w_d;
         end
         ri = gnt_i || (gap_i == 0 && left_i > 0);
         rd = gnt_d || (gap_d == 0 && left_d > 0);
         if (!busy && cyc >= next_free && (ri || rd)) begin
            busy_d    = rd && (!ri || !last_d);
            last_d    = busy_d;
            busy      = 1'b1;
            t_grant   = cyc;
            t_len     = $urandom_range(1, 4);
            b_rdata   = {4{$urandom}};
            mem_delay = t_len;
            mem_data  = b_rdata;
            b_addr    = busy_d ? a_d : a_i;
            b_write   = busy_d && wr_d;
            b_wdata   = w_d;
            gnt_i     = !busy_d;
            gnt_d     = busy_d;
         end
         tick();
         cyc++;
         exp_strobe = busy && cyc >= t_grant + 1 && cyc <= t_grant + t_len;
         n_checks++;
         if (bus.pmem_read !== (exp_strobe && !b_write) || bus.pmem_write !== (exp_strobe && b_write) || bus.grant_d !== (exp_strobe && busy_d)) begin
            n_fail++;
            $display("[TB] FAIL rand_strobe cyc=%0d: got r=%b w=%b g=%b expected r=%b w=%b g=%b", cyc, bus.pmem_read, bus.pmem_write, bus.grant_d, exp_strobe && !b_write, exp_strobe && b_write, exp_strobe && busy_d);
         end
         if (exp_strobe) begin
            n_checks++;
            if (bus.pmem_address !== b_addr || (b_write && bus.pmem_wdata !== b_wdata)) begin
               n_fail++;
               $display("[TB] FAIL rand_capture cyc=%0d: got a=%h d=%h expected a=%h d=%h", cyc, bus.pmem_address, bus.pmem_wdata, b_addr, b_wdata);
            end
         end
         er_i = busy && !busy_d && cyc == t_grant + t_len + 1;
         er_d = busy && busy_d && cyc == t_grant + t_len + 1;
         n_checks++;
         if (bus.i_resp !== er_i || bus.d_resp !== er_d) begin
            n_fail++;
            $display("[TB] FAIL rand_resp cyc=%0d: got i=%b d=%b expected i=%b d=%b", cyc, bus.i_resp, bus.d_resp, er_i, er_d);
         end
         if (er_i) begin
            n_checks++;
            if (bus.i_rdata !== b_rdata) begin
               n_fail++;
               $display("[TB] FAIL rand_i_rdata cyc=%0d: got %h expected %h", cyc, bus.i_rdata, b_rdata);
            end
            gnt_i = 1'b0;
            left_i--;
            a_i   = ADDR_W'($urandom);
            gap_i = $urandom_range(1, 4);
         end
         if (er_d) begin
            if (!b_write) begin
               n_checks++;
               if (bus.d_rdata !== b_rdata) begin
                  n_fail++;
                  $display("[TB] FAIL rand_d_rdata cyc=%0d: got %h expected %h", cyc, bus.d_rdata, b_rdata);
               end
            end
            gnt_d = 1'b0;
            left_d--;
            a_d   = ADDR_W'($urandom);
            w_d   = {4{$urandom}};
            wr_d  = 1'($urandom_range(0, 1));
            gap_d = $urandom_range(1, 4);
         end
         if (er_i || er_d) begin
            busy      = 1'b0;
            next_free = cyc + 1;
         end
      end
      if (cyc >= 3000) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL rand_timeout: got %0d/%0d left expected 0/0", left_i, left_d);
      end
      bus.i_read  = 1'b0;
      bus.d_read  = 1'b0;
      bus.d_write = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_i_only();
      test_d_write();
      test_tie_after_reset();
      test_back_to_back();
      test_reset_mid_op();
      test_long_wait();
      test_random_traffic();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
